// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the multi-channel I2C target.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } i2c_state_e;

  localparam logic I2C_RELEASE = 1'b1;
  localparam logic I2C_PULL    = 1'b0;

  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h22;

endpackage

// File: rtl/i2c_multi_target_if.sv
// Bus bundle for the multi-channel I2C target; one bit per independent bus.
interface i2c_multi_target_if #(
  parameter int NUM_I2C_BUSSES = 1
);
  logic [NUM_I2C_BUSSES-1:0] scl_i;
  logic [NUM_I2C_BUSSES-1:0] sda_i;
  logic [NUM_I2C_BUSSES-1:0] scl_o;
  logic [NUM_I2C_BUSSES-1:0] sda_o;
  logic [NUM_I2C_BUSSES-1:0] busy_o;
  logic [NUM_I2C_BUSSES-1:0] wr_done_o;
  logic [NUM_I2C_BUSSES-1:0] rd_done_o;

  modport slave  (input  scl_i, sda_i, output scl_o, sda_o, busy_o, wr_done_o, rd_done_o);
  modport master (output scl_i, sda_i, input  scl_o, sda_o, busy_o, wr_done_o, rd_done_o);
endinterface

// File: rtl/i2c_target_chan.sv
// One I2C target channel: input sync, protocol FSM, byte memory with a
// persistent pointer, and optional SCL stretch after every ACK bit.
module i2c_target_chan
  import i2c_target_pkg::*;
#(
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int I2C_DATA_WIDTH = 8,
  parameter int MEM_DEPTH      = 16,
  parameter int STRETCH_CYCLES = 0,
  parameter logic [I2C_ADDR_WIDTH-1:0] CHAN_ADDR = '0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_o,
  output logic sda_o,
  output logic busy_o,
  output logic wr_done_o,
  output logic rd_done_o
);
  localparam int SHW = (I2C_ADDR_WIDTH + 1 > I2C_DATA_WIDTH) ? I2C_ADDR_WIDTH + 1 : I2C_DATA_WIDTH;
  localparam int PW  = $clog2(MEM_DEPTH);
  localparam int CW  = $clog2(SHW + 1);
  localparam int SW  = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
  localparam logic [SW-1:0] STRETCH_LOAD = SW'((STRETCH_CYCLES > 0) ? STRETCH_CYCLES - 1 : 0);
  localparam logic [CW-1:0] ADDR_BITS    = CW'(I2C_ADDR_WIDTH + 1);
  localparam logic [CW-1:0] DATA_BITS    = CW'(I2C_DATA_WIDTH);

  i2c_state_e                state_q;
  logic [1:0]                scl_sync_q, sda_sync_q;
  logic                      scl_prev_q, sda_prev_q;
  logic [SHW-1:0]            shreg_q;
  logic [CW-1:0]             bitcnt_q;
  logic [PW-1:0]             ptr_q;
  logic [I2C_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [SW-1:0]             stretch_q;
  logic rw_q, wrote_q, scl_q, sda_q, busy_q, wr_done_q, rd_done_q;

  logic scl_s, sda_s, scl_rise, scl_fall, start_c, stop_c, ack_end_c;
  logic [SHW-1:0]            shreg_d;
  logic [I2C_DATA_WIDTH-1:0] rd_byte;

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_c   = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_c    = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign ack_end_c = scl_fall && (state_q inside {ADDR_ACK, PTR_ACK, WR_ACK, RD_ACK});
  assign shreg_d   = {shreg_q[SHW-2:0], sda_s};
  assign rd_byte   = mem_q[ptr_q];

  assign scl_o     = scl_q;
  assign sda_o     = sda_q;
  assign busy_o    = busy_q;
  assign wr_done_o = wr_done_q;
  assign rd_done_o = rd_done_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= IDLE;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      ptr_q      <= '0;
      stretch_q  <= '0;
      rw_q       <= 1'b0;
      wrote_q    <= 1'b0;
      scl_q      <= I2C_RELEASE;
      sda_q      <= I2C_RELEASE;
      busy_q     <= 1'b0;
      wr_done_q  <= 1'b0;
      rd_done_q  <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      wr_done_q  <= 1'b0;
      rd_done_q  <= 1'b0;

      // Stretch window opens the cycle after the fall that closes an ACK bit.
      if (STRETCH_CYCLES > 0 && ack_end_c) begin
        scl_q     <= I2C_PULL;
        stretch_q <= STRETCH_LOAD;
      end else if (scl_q == I2C_PULL) begin
        if (stretch_q == '0) scl_q <= I2C_RELEASE;
        else                 stretch_q <= stretch_q - 1'b1;
      end

      if (stop_c) begin
        state_q   <= IDLE;
        sda_q     <= I2C_RELEASE;
        busy_q    <= 1'b0;
        wr_done_q <= wrote_q;
        wrote_q   <= 1'b0;
      end else if (start_c) begin
        state_q  <= ADDR;
        bitcnt_q <= '0;
        sda_q    <= I2C_RELEASE;
        wrote_q  <= 1'b0;
      end else if (scl_rise) begin
        case (state_q)
          ADDR, PTR, WR_DATA: begin
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_q + 1'b1;
          end
          RD_DATA: bitcnt_q <= bitcnt_q + 1'b1;
          RD_ACK: begin
            if (sda_s) begin
              rd_done_q <= 1'b1;
              state_q   <= IGNORE;
            end else begin
              ptr_q <= ptr_q + 1'b1;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state_q)
          ADDR: if (bitcnt_q == ADDR_BITS) begin
            if (shreg_q[I2C_ADDR_WIDTH:1] == CHAN_ADDR) begin
              state_q <= ADDR_ACK;
              sda_q   <= I2C_PULL;
              busy_q  <= 1'b1;
              rw_q    <= shreg_q[0];
            end else begin
              state_q <= IGNORE;
              sda_q   <= I2C_RELEASE;
              busy_q  <= 1'b0;
            end
          end
          ADDR_ACK: begin
            bitcnt_q <= '0;
            if (rw_q) begin
              state_q <= RD_DATA;
              shreg_q <= SHW'(rd_byte);
              sda_q   <= rd_byte[I2C_DATA_WIDTH-1];
            end else begin
              state_q <= PTR;
              sda_q   <= I2C_RELEASE;
            end
          end
          PTR: if (bitcnt_q == DATA_BITS) begin
            ptr_q   <= shreg_q[PW-1:0];
            sda_q   <= I2C_PULL;
            state_q <= PTR_ACK;
          end
          WR_DATA: if (bitcnt_q == DATA_BITS) begin
            mem_q[ptr_q] <= shreg_q[I2C_DATA_WIDTH-1:0];
            wrote_q      <= 1'b1;
            sda_q        <= I2C_PULL;
            state_q      <= WR_ACK;
          end
          PTR_ACK, WR_ACK: begin
            if (state_q == WR_ACK) ptr_q <= ptr_q + 1'b1;
            sda_q    <= I2C_RELEASE;
            bitcnt_q <= '0;
            state_q  <= WR_DATA;
          end
          RD_DATA: begin
            if (bitcnt_q == DATA_BITS) begin
              sda_q   <= I2C_RELEASE;
              state_q <= RD_ACK;
            end else begin
              shreg_q <= shreg_q << 1;
              sda_q   <= shreg_q[I2C_DATA_WIDTH-2];
            end
          end
          RD_ACK: begin
            bitcnt_q <= '0;
            state_q  <= RD_DATA;
            shreg_q  <= SHW'(rd_byte);
            sda_q    <= rd_byte[I2C_DATA_WIDTH-1];
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/i2c_multi_target.sv
// Array of independent I2C target channels; channel k answers BASE_ADDR+k.
module i2c_multi_target
  import i2c_target_pkg::*;
#(
  parameter int NUM_I2C_BUSSES = 1,
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int I2C_DATA_WIDTH = 8,
  parameter int MEM_DEPTH      = 16,
  parameter logic [I2C_ADDR_WIDTH-1:0] BASE_ADDR = I2C_ADDR_WIDTH'(I2C_DEFAULT_ADDR),
  parameter int STRETCH_CYCLES = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  i2c_multi_target_if.slave bus
);
  logic [NUM_I2C_BUSSES-1:0] scl_o_w, sda_o_w, busy_w, wr_done_w, rd_done_w;

  for (genvar k = 0; k < NUM_I2C_BUSSES; k++) begin : g_chan
    i2c_target_chan #(
      .I2C_ADDR_WIDTH (I2C_ADDR_WIDTH),
      .I2C_DATA_WIDTH (I2C_DATA_WIDTH),
      .MEM_DEPTH      (MEM_DEPTH),
      .STRETCH_CYCLES (STRETCH_CYCLES),
      .CHAN_ADDR      (I2C_ADDR_WIDTH'(BASE_ADDR + k))
    ) u_chan (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .scl_i     (bus.scl_i[k]),
      .sda_i     (bus.sda_i[k]),
      .scl_o     (scl_o_w[k]),
      .sda_o     (sda_o_w[k]),
      .busy_o    (busy_w[k]),
      .wr_done_o (wr_done_w[k]),
      .rd_done_o (rd_done_w[k])
    );
  end

  assign bus.scl_o     = scl_o_w;
  assign bus.sda_o     = sda_o_w;
  assign bus.busy_o    = busy_w;
  assign bus.wr_done_o = wr_done_w;
  assign bus.rd_done_o = rd_done_w;

endmodule

// File: tb/tb_i2c_multi_target.sv
// Directed bench: bit-banged I2C masters on four open-drain buses, target
// with five-cycle stretch; checks ACKs, data, pulses, stretch and reset.
module tb_i2c_multi_target;
  localparam int Q = 8;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] m_scl, m_sda;
  int nvec = 0, nerr = 0;

  int run[4], st_ev[4], st_bad[4], wr_cnt[4], rd_cnt[4], sda_low[4];

  i2c_multi_target_if #(.NUM_I2C_BUSSES(4)) bus ();

  assign bus.scl_i = m_scl & bus.scl_o;
  assign bus.sda_i = m_sda & bus.sda_o;

  i2c_multi_target #(
    .NUM_I2C_BUSSES (4),
    .I2C_ADDR_WIDTH (7),
    .I2C_DATA_WIDTH (8),
    .MEM_DEPTH      (16),
    .BASE_ADDR      (7'h22),
    .STRETCH_CYCLES (5)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    for (int k = 0; k < 4; k++) begin
      run[k] = 0; st_ev[k] = 0; st_bad[k] = 0; wr_cnt[k] = 0; rd_cnt[k] = 0; sda_low[k] = 0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (!bus.scl_o[k]) run[k] <= run[k] + 1;
      else if (run[k] != 0) begin
        st_ev[k] <= st_ev[k] + 1;
        if (run[k] != 5) st_bad[k] <= st_bad[k] + 1;
        run[k] <= 0;
      end
      if (bus.wr_done_o[k]) wr_cnt[k] <= wr_cnt[k] + 1;
      if (bus.rd_done_o[k]) rd_cnt[k] <= rd_cnt[k] + 1;
      if (!bus.sda_o[k])    sda_low[k] <= sda_low[k] + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic i2c_start(input int b);
    m_sda[b] = 1'b1; tick(Q);
    m_scl[b] = 1'b1; tick(Q);
    m_sda[b] = 1'b0; tick(Q);
    m_scl[b] = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop(input int b);
    m_sda[b] = 1'b0; tick(Q);
    m_scl[b] = 1'b1; tick(Q);
    m_sda[b] = 1'b1; tick(Q);
  endtask

  task automatic i2c_bit(input int b, input logic tx, output logic rx);
    m_sda[b] = tx;   tick(Q);
    m_scl[b] = 1'b1; tick(Q);
    rx = bus.sda_i[b]; tick(Q);
    m_scl[b] = 1'b0; tick(Q);
  endtask

  task automatic i2c_wr(input int b, input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) i2c_bit(b, d[i], r);
    i2c_bit(b, 1'b1, ack);
  endtask

  task automatic i2c_rd(input int b, input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(b, 1'b1, r);
      d[i] = r;
    end
    i2c_bit(b, nack, r);
  endtask

  logic a, a0, a3, a3b, a3c, a0b, b0, b3;
  logic [7:0] d0, d1;
  int snap, snap_wr, snap_rd;

  initial begin
    rst = 1'b1;
    m_scl = 4'hF;
    m_sda = 4'hF;
    tick(4);
    chk("rst_scl_o", bus.scl_o, 4'hF);
    chk("rst_sda_o", bus.sda_o, 4'hF);
    chk("rst_busy", bus.busy_o, 4'h0);
    chk("rst_wr_done", bus.wr_done_o, 4'h0);
    chk("rst_rd_done", bus.rd_done_o, 4'h0);
    rst = 1'b0;
    tick(4);

    // write ptr 3, data A5 5A
    i2c_start(0);
    i2c_wr(0, 8'h44, a); chk("w_addr_ack", a, 0);
    chk("busy_on_match", bus.busy_o[0], 1);
    i2c_wr(0, 8'h03, a); chk("w_ptr_ack", a, 0);
    i2c_wr(0, 8'hA5, a); chk("w_d0_ack", a, 0);
    i2c_wr(0, 8'h5A, a); chk("w_d1_ack", a, 0);
    i2c_stop(0); tick(4);
    chk("wr_done_pulse", wr_cnt[0], 1);
    chk("stretch_runs_w", st_ev[0], 4);
    chk("busy_after_stop", bus.busy_o[0], 0);

    // set ptr 3, repeated start, read two bytes
    i2c_start(0);
    i2c_wr(0, 8'h44, a); chk("r_addr_ack", a, 0);
    i2c_wr(0, 8'h03, a); chk("r_ptr_ack", a, 0);
    i2c_start(0);
    i2c_wr(0, 8'h45, a); chk("r_addr_rd_ack", a, 0);
    i2c_rd(0, 1'b0, d0);
    i2c_rd(0, 1'b1, d1);
    i2c_stop(0); tick(4);
    chk("rd_byte0", d0, 8'hA5);
    chk("rd_byte1", d1, 8'h5A);
    chk("rd_done_pulse", rd_cnt[0], 1);
    chk("no_wr_done_on_read", wr_cnt[0], 1);
    chk("stretch_runs_r", st_ev[0], 8);

    // pointer wrap on write and read
    i2c_start(0);
    i2c_wr(0, 8'h44, a);
    i2c_wr(0, 8'h0F, a);
    i2c_wr(0, 8'h11, a); chk("wrap_w0_ack", a, 0);
    i2c_wr(0, 8'h22, a); chk("wrap_w1_ack", a, 0);
    i2c_stop(0);
    i2c_start(0);
    i2c_wr(0, 8'h44, a);
    i2c_wr(0, 8'h0F, a);
    i2c_start(0);
    i2c_wr(0, 8'h45, a);
    i2c_rd(0, 1'b0, d0);
    i2c_rd(0, 1'b1, d1);
    i2c_stop(0); tick(4);
    chk("wrap_mem15", d0, 8'h11);
    chk("wrap_mem0", d1, 8'h22);
    chk("wrap_wr_done", wr_cnt[0], 2);

    // address 0x25 on bus 3 and bus 0 at the same time
    snap = sda_low[0];
    fork
      begin
        i2c_start(3);
        i2c_wr(3, 8'h4A, a3); b3 = bus.busy_o[3];
        i2c_wr(3, 8'h07, a3b);
        i2c_wr(3, 8'h3C, a3c);
        i2c_stop(3);
      end
      begin
        i2c_start(0);
        i2c_wr(0, 8'h4A, a0); b0 = bus.busy_o[0];
        i2c_wr(0, 8'h07, a0b);
        i2c_stop(0);
      end
    join
    tick(4);
    chk("bus3_addr_ack", a3, 0);
    chk("bus3_busy", b3, 1);
    chk("bus3_ptr_ack", a3b, 0);
    chk("bus3_data_ack", a3c, 0);
    chk("bus0_addr_nack", a0, 1);
    chk("bus0_not_busy", b0, 0);
    chk("bus0_ignored_nack", a0b, 1);
    chk("bus0_sda_never_low", sda_low[0] - snap, 0);
    chk("bus3_wr_done", wr_cnt[3], 1);
    i2c_start(3);
    i2c_wr(3, 8'h4A, a);
    i2c_wr(3, 8'h07, a);
    i2c_start(3);
    i2c_wr(3, 8'h4B, a);
    i2c_rd(3, 1'b1, d0);
    i2c_stop(3); tick(4);
    chk("bus3_readback", d0, 8'h3C);

    // reset while the target drives a 0 data bit
    i2c_start(0);
    i2c_wr(0, 8'h44, a);
    i2c_wr(0, 8'h0F, a);
    i2c_start(0);
    i2c_wr(0, 8'h45, a);
    tick(2);
    chk("rd_msb_low", bus.sda_o[0], 0);
    snap_wr = wr_cnt[0];
    snap_rd = rd_cnt[0];
    #2 rst = 1'b1;
    #1;
    chk("async_rst_sda", bus.sda_o[0], 1);
    chk("async_rst_scl", bus.scl_o, 4'hF);
    tick(3);
    rst = 1'b0;
    tick(4);
    chk("rst_busy_clear", bus.busy_o, 4'h0);
    i2c_stop(0);
    i2c_start(0);
    i2c_wr(0, 8'h44, a); chk("post_rst_addr_ack", a, 0);
    i2c_wr(0, 8'h03, a);
    i2c_start(0);
    i2c_wr(0, 8'h45, a);
    i2c_rd(0, 1'b1, d0);
    i2c_stop(0); tick(4);
    chk("post_rst_mem_zero", d0, 8'h00);
    chk("no_wr_pulse_after_rst", wr_cnt[0] - snap_wr, 0);
    chk("rd_pulse_after_rst", rd_cnt[0] - snap_rd, 1);
    chk("stretch_len_bus0", st_bad[0], 0);
    chk("stretch_len_bus3", st_bad[3], 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
